// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - iteration control FSM for the four-PLU Maxnet datapath
module maxnet_controller #(
    parameter int MAX_ITER     = 64,
    parameter int ITER_W       = 8,
    parameter int WAIT_TIMEOUT = 255,
    parameter int TO_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              plu1_done,
    input  logic              plu2_done,
    input  logic              plu3_done,
    input  logic              plu4_done,
    input  logic              finish,
    output logic              plu_start,
    output logic              mux_sel,
    output logic              we_a_reg,
    output logic              we_prim,
    output logic              busy,
    output logic              done,
    output logic              iter_limit,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]      state;
    logic [3:0]      done_flags;
    logic [TO_W-1:0] wait_cnt;

    logic [3:0]      done_now;
    logic            all_done;
    logic [TO_W-1:0] wait_cnt_next;
    logic            wait_expired;
    logic            iter_at_limit;
    logic            iter_at_max;

    // A done arriving in the same cycle as the check still counts toward completion.
    assign done_now      = done_flags | {plu4_done, plu3_done, plu2_done, plu1_done};
    assign all_done      = &done_now;
    assign wait_cnt_next = wait_cnt + TO_W'(1);
    assign wait_expired  = (wait_cnt_next == TO_W'(WAIT_TIMEOUT));
    assign iter_at_limit = (iter_count == ITER_W'(MAX_ITER));
    assign iter_at_max   = (iter_count == {ITER_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            done_flags <= '0;
            wait_cnt   <= '0;
            iter_count <= '0;
            iter_limit <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        iter_count <= '0;
                        iter_limit <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    done_flags <= '0;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    done_flags <= done_now;
                    wait_cnt   <= wait_cnt_next;
                    if (all_done) begin
                        state <= S_UPDATE;
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_UPDATE: begin
                    if (!iter_at_max) begin
                        iter_count <= iter_count + ITER_W'(1);
                    end
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (finish) begin
                        state <= S_DONE;
                    end else if (iter_at_limit) begin
                        iter_limit <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign plu_start = (state == S_RUN);
    assign mux_sel   = (state == S_UPDATE);
    assign we_a_reg  = (state == S_LOAD) || (state == S_UPDATE);
    assign we_prim   = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - directed bench for maxnet_controller
module tb_maxnet_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       plu1_done = 1'b0, plu2_done = 1'b0, plu3_done = 1'b0, plu4_done = 1'b0;
    logic       finish = 1'b0;
    logic       plu_start, mux_sel, we_a_reg, we_prim, busy, done, iter_limit, timeout;
    logic [7:0] iter_count;

    int vectors = 0;
    int miscompares = 0;
    bit monitor_on = 1'b0;

    maxnet_controller #(.MAX_ITER(4), .ITER_W(8), .WAIT_TIMEOUT(10), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .plu1_done(plu1_done), .plu2_done(plu2_done), .plu3_done(plu3_done), .plu4_done(plu4_done),
        .finish(finish), .plu_start(plu_start), .mux_sel(mux_sel), .we_a_reg(we_a_reg),
        .we_prim(we_prim), .busy(busy), .done(done), .iter_limit(iter_limit),
        .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_dones(input logic [3:0] d);
        {plu4_done, plu3_done, plu2_done, plu1_done} = d;
    endtask

    // Mutual exclusion of the strobes, checked every cycle while stimulus runs.
    always @(negedge clk) begin
        if (monitor_on && !rst) begin
            vectors++;
            if ((int'(plu_start) + int'(we_a_reg) + int'(done)) > 1 || (we_prim && (!we_a_reg || mux_sel))) begin
                miscompares++;
                $display("FAIL strobe_exclusive: got ps=%b we=%b dn=%b wp=%b ms=%b", plu_start, we_a_reg, done, we_prim, mux_sel);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        tick; tick; tick;
        vectors++;
        if ({plu_start, mux_sel, we_a_reg, we_prim, busy, done, iter_limit, timeout} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000000", {plu_start, mux_sel, we_a_reg, we_prim, busy, done, iter_limit, timeout});
        end
        vectors++;
        if (iter_count !== 8'd0) begin miscompares++; $display("FAIL reset_iter_count: got %0d want 0", iter_count); end
        rst = 1'b0;
        monitor_on = 1'b1;
    endtask

    task automatic test_single_iter;
        start = 1'b1; tick; start = 1'b0;            // c1 LOAD
        vectors++;
        if ({we_prim, we_a_reg, mux_sel, busy} !== 4'b1101) begin
            miscompares++; $display("FAIL single_load: got %b want 1101", {we_prim, we_a_reg, mux_sel, busy});
        end
        tick;                                         // c2 RUN
        vectors++;
        if (plu_start !== 1'b1) begin miscompares++; $display("FAIL single_plu_start_c2: got %b want 1", plu_start); end
        tick; tick; tick;                             // c5 WAIT
        set_dones(4'b1111);
        vectors++;
        if (we_a_reg !== 1'b0) begin miscompares++; $display("FAIL single_wait_we: got %b want 0", we_a_reg); end
        tick; set_dones(4'b0000); finish = 1'b1;      // c6 UPDATE
        vectors++;
        if ({we_a_reg, mux_sel} !== 2'b11) begin miscompares++; $display("FAIL single_update: got %b want 11", {we_a_reg, mux_sel}); end
        tick;                                         // c7 CHECK
        vectors++;
        if (done !== 1'b0 || iter_count !== 8'd1) begin
            miscompares++; $display("FAIL single_check: got done=%b iter=%0d want done=0 iter=1", done, iter_count);
        end
        tick; finish = 1'b0;                          // c8 DONE
        vectors++;
        if ({done, iter_limit, timeout} !== 3'b100 || iter_count !== 8'd1) begin
            miscompares++; $display("FAIL single_done_c8: got %b iter=%0d want 100 iter=1", {done, iter_limit, timeout}, iter_count);
        end
        tick;
        vectors++;
        if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL single_idle: got %b want 00", {done, busy}); end
    endtask

    task automatic test_stagger;
        int early = 0;
        start = 1'b1; tick; start = 1'b0;            // c1
        tick;                                         // c2 RUN
        for (int c = 3; c <= 11; c++) begin
            tick;
            case (c)
                3:       set_dones(4'b0100);
                6:       set_dones(4'b0001);
                9:       set_dones(4'b1000);
                11:      set_dones(4'b0010);
                default: set_dones(4'b0000);
            endcase
            if (we_a_reg) early++;
        end
        tick; set_dones(4'b0000); finish = 1'b1;      // c12
        vectors++;
        if (early !== 0) begin miscompares++; $display("FAIL stagger_early_update: got %0d want 0", early); end
        vectors++;
        if ({we_a_reg, mux_sel} !== 2'b11) begin miscompares++; $display("FAIL stagger_update_c12: got %b want 11", {we_a_reg, mux_sel}); end
        tick; tick; finish = 1'b0;                    // c14 DONE
        vectors++;
        if (done !== 1'b1 || iter_count !== 8'd1) begin
            miscompares++; $display("FAIL stagger_done: got done=%b iter=%0d want 1 iter=1", done, iter_count);
        end
        tick;
    endtask

    task automatic test_iter_limit;
        int pulses = 0;
        start = 1'b1; tick; start = 1'b0;            // c1
        for (int k = 0; k < 4; k++) begin
            tick;                                     // RUN
            if (plu_start) pulses++;
            tick; set_dones(4'b1111);                 // WAIT
            tick; set_dones(4'b0000);                 // UPDATE
            tick;                                     // CHECK
            vectors++;
            if (iter_count !== 8'(k + 1)) begin
                miscompares++; $display("FAIL limit_iter_count_%0d: got %0d want %0d", k, iter_count, k + 1);
            end
        end
        tick;                                         // DONE
        vectors++;
        if (pulses !== 4) begin miscompares++; $display("FAIL limit_pulses: got %0d want 4", pulses); end
        vectors++;
        if ({done, iter_limit, timeout} !== 3'b110 || iter_count !== 8'd4) begin
            miscompares++; $display("FAIL limit_done: got %b iter=%0d want 110 iter=4", {done, iter_limit, timeout}, iter_count);
        end
        tick;
        vectors++;
        if ({busy, iter_limit} !== 2'b01 || iter_count !== 8'd4) begin
            miscompares++; $display("FAIL limit_hold: got %b iter=%0d want 01 iter=4", {busy, iter_limit}, iter_count);
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        start = 1'b1; tick; start = 1'b0;            // c1
        vectors++;
        if ({iter_limit, timeout} !== 2'b00 || iter_count !== 8'd0) begin
            miscompares++; $display("FAIL timeout_clear_on_start: got %b iter=%0d want 00 iter=0", {iter_limit, timeout}, iter_count);
        end
        tick;                                         // c2 RUN
        tick; set_dones(4'b0111);                     // c3
        for (int c = 3; c <= 12; c++) begin
            if (we_a_reg || done || !busy) bad++;
            tick;
            set_dones(4'b0000);
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL timeout_wait_window: got %0d bad cycles want 0", bad); end
        vectors++;
        if ({done, timeout, iter_limit} !== 3'b110) begin
            miscompares++; $display("FAIL timeout_done_c13: got %b want 110", {done, timeout, iter_limit});
        end
        tick;
        vectors++;
        if ({busy, timeout, we_a_reg} !== 3'b010) begin
            miscompares++; $display("FAIL timeout_hold: got %b want 010", {busy, timeout, we_a_reg});
        end
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int loads = 0;
        start = 1'b1; tick; start = 1'b0;            // c1
        tick; tick;                                   // c3 WAIT
        start = 1'b1;
        tick;                                         // c4
        if (we_prim) loads++;
        tick; start = 1'b0; set_dones(4'b1111); finish = 1'b1;   // c5
        if (we_prim) loads++;
        for (int i = 0; i < 10; i++) begin
            tick; set_dones(4'b0000);
            if (done) dones++;
            if (we_prim) loads++;
        end
        finish = 1'b0;
        vectors++;
        if (dones !== 1) begin miscompares++; $display("FAIL ignored_done_count: got %0d want 1", dones); end
        vectors++;
        if (loads !== 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL ignored_reload: got loads=%0d busy=%b want 0 0", loads, busy);
        end
    endtask

    task automatic test_start_held;
        start = 1'b1; tick;                           // c1
        tick;                                         // c2
        tick; set_dones(4'b1111); finish = 1'b1;      // c3
        tick; set_dones(4'b0000);                     // c4
        tick;                                         // c5
        tick;                                         // c6 DONE
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL held_done_c6: got %b want 1", done); end
        tick;                                         // c7 IDLE
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL held_idle_c7: got %b want 0", busy); end
        tick; start = 1'b0;                           // c8 LOAD
        vectors++;
        if ({we_prim, busy} !== 2'b11) begin miscompares++; $display("FAIL held_retrigger_c8: got %b want 11", {we_prim, busy}); end
        tick;                                         // c9 RUN
        tick; set_dones(4'b1111);                     // c10
        tick; set_dones(4'b0000);                     // c11
        tick; tick;                                   // c13 DONE
        finish = 1'b0;
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("FAIL held_second_done: got %b want 1", done); end
        tick;
    endtask

    task automatic test_mid_run_reset;
        start = 1'b1; tick; start = 1'b0;            // c1
        tick;                                         // c2
        tick; set_dones(4'b1111);                     // c3
        tick; set_dones(4'b0000);                     // c4
        tick;                                         // c5 CHECK, finish=0
        tick;                                         // c6 RUN
        tick; set_dones(4'b1101);                     // c7 WAIT
        tick; set_dones(4'b0000);                     // c8 WAIT
        vectors++;
        if ({busy, we_a_reg} !== 2'b10 || iter_count !== 8'd1) begin
            miscompares++; $display("FAIL midreset_pre: got %b iter=%0d want 10 iter=1", {busy, we_a_reg}, iter_count);
        end
        rst = 1'b1;
        tick; tick; tick;
        rst = 1'b0;
        vectors++;
        if ({plu_start, mux_sel, we_a_reg, we_prim, busy, done, iter_limit, timeout} !== 8'b0 || iter_count !== 8'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b iter=%0d want 00000000 iter=0", {plu_start, mux_sel, we_a_reg, we_prim, busy, done, iter_limit, timeout}, iter_count);
        end
        plu2_done = 1'b1;
        tick; plu2_done = 1'b0;
        tick; tick;
        vectors++;
        if ({busy, we_a_reg, done} !== 3'b000) begin
            miscompares++; $display("FAIL midreset_late_done: got %b want 000", {busy, we_a_reg, done});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_iter;
        test_stagger;
        test_iter_limit;
        test_timeout;
        test_start_ignored;
        test_start_held;
        test_mid_run_reset;
        monitor_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
